// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset sequencer: state codes,
// opcodes, funct3 branch codes and datapath select encodings.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_IMM = 2'b01;
  localparam logic [1:0] PCSEL_ALU = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_LINK = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath
// (slave): instruction fields and comparator flags in, datapath enables out.
interface multicycle_control_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       BrEq;
  logic       BrLT;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       memRead;
  logic       memWrite;
  logic       regWrite;
  logic [1:0] memtoReg;
  logic [1:0] ALUOp;
  logic       ALUSrc;
  logic [1:0] PCSel;
  logic       IorD;
  logic       instr_done;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  opcode, funct3, BrEq, BrLT, mem_ready,
    output PCWrite, IRWrite, memRead, memWrite, regWrite, memtoReg,
           ALUOp, ALUSrc, PCSel, IorD, instr_done, illegal, state
  );

  modport slave (
    output opcode, funct3, BrEq, BrLT, mem_ready,
    input  PCWrite, IRWrite, memRead, memWrite, regWrite, memtoReg,
           ALUOp, ALUSrc, PCSel, IorD, instr_done, illegal, state
  );

endinterface

// File: rtl/multicycle_control_branch_resolve.sv
// Branch-taken decision from funct3 and the comparator flags; purely
// combinational so a pipelined core can reuse it unchanged.
module multicycle_control_branch_resolve
  import multicycle_control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       taken
);

  // Map the four supported branch conditions; anything else never branches
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = BrEq;
      F3_BNE:  taken = ~BrEq;
      F3_BLT:  taken = BrLT;
      F3_BGE:  taken = ~BrLT;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the shared datapath enables, stalling on the memory ready handshake.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [6:0] op_r;
  logic [2:0] f3_r;
  logic       taken_s;

  multicycle_control_branch_resolve u_branch_resolve (
    .funct3 (f3_r),
    .BrEq   (bus.BrEq),
    .BrLT   (bus.BrLT),
    .taken  (taken_s)
  );

  // State register and instruction-field copy; the IR only holds the new
  // instruction once DECODE is entered, so the copy is taken leaving DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
      op_r    <= 7'd0;
      f3_r    <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == DECODE) begin
        op_r <= bus.opcode;
        f3_r <= bus.funct3;
      end
    end
  end

  // Datapath enables and next state; reset forces every output low at once
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.memRead    = 1'b0;
    bus.memWrite   = 1'b0;
    bus.regWrite   = 1'b0;
    bus.memtoReg   = M2R_ALU;
    bus.ALUOp      = ALUOP_ADD;
    bus.ALUSrc     = 1'b0;
    bus.PCSel      = PCSEL_PC4;
    bus.IorD       = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    bus.state      = FETCH;
    state_nxt_s    = FETCH;
    if (rst) begin
      state_nxt_s = FETCH;
    end else begin
      bus.state = state_r;
      case (state_r)
        FETCH: begin
          bus.memRead = 1'b1;
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            bus.PCSel   = PCSEL_PC4;
            state_nxt_s = DECODE;
          end else begin
            state_nxt_s = FETCH;
          end
        end
        DECODE: begin
          if (op_supported(bus.opcode)) begin
            state_nxt_s = EXEC;
          end else begin
            bus.illegal    = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt_s    = FETCH;
          end
        end
        EXEC: begin
          case (op_r)
            OP_R: begin
              bus.ALUOp   = ALUOP_R;
              bus.ALUSrc  = 1'b0;
              state_nxt_s = WB;
            end
            OP_I: begin
              bus.ALUOp   = ALUOP_I;
              bus.ALUSrc  = 1'b1;
              state_nxt_s = WB;
            end
            OP_LW, OP_SW: begin
              bus.ALUOp   = ALUOP_ADD;
              bus.ALUSrc  = 1'b1;
              state_nxt_s = MEM;
            end
            OP_BR: begin
              bus.PCSel      = PCSEL_IMM;
              bus.PCWrite    = taken_s;
              bus.instr_done = 1'b1;
              state_nxt_s    = FETCH;
            end
            OP_JAL: begin
              bus.PCSel   = PCSEL_IMM;
              bus.PCWrite = 1'b1;
              state_nxt_s = WB;
            end
            OP_JALR: begin
              bus.ALUOp   = ALUOP_ADD;
              bus.ALUSrc  = 1'b1;
              bus.PCSel   = PCSEL_ALU;
              bus.PCWrite = 1'b1;
              state_nxt_s = WB;
            end
            default: state_nxt_s = FETCH;
          endcase
        end
        MEM: begin
          bus.IorD   = 1'b1;
          bus.ALUOp  = ALUOP_ADD;
          bus.ALUSrc = 1'b1;
          if (op_r == OP_SW) begin
            bus.memWrite = 1'b1;
          end else begin
            bus.memRead = 1'b1;
          end
          if (!bus.mem_ready) begin
            state_nxt_s = MEM;
          end else if (op_r == OP_SW) begin
            bus.instr_done = 1'b1;
            state_nxt_s    = FETCH;
          end else begin
            state_nxt_s = WB;
          end
        end
        WB: begin
          bus.regWrite   = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt_s    = FETCH;
          case (op_r)
            OP_LW:           bus.memtoReg = M2R_MEM;
            OP_JAL, OP_JALR: bus.memtoReg = M2R_LINK;
            default:         bus.memtoReg = M2R_ALU;
          endcase
        end
        default: state_nxt_s = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step drives inputs, checks the
// full output vector against a hand-computed value, then advances one clock.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output vector, field order:
  // PCWrite IRWrite memRead memWrite regWrite memtoReg ALUOp ALUSrc PCSel IorD instr_done illegal state
  function automatic logic [17:0] v(
    input logic pcw, input logic irw, input logic mrd, input logic mwr, input logic rw,
    input logic [1:0] m2r, input logic [1:0] aop, input logic asrc, input logic [1:0] psel,
    input logic iord, input logic idone, input logic ill, input logic [2:0] st);
    return {pcw, irw, mrd, mwr, rw, m2r, aop, asrc, psel, iord, idone, ill, st};
  endfunction

  task automatic step(input string tag, input logic mr, input logic [17:0] exp_v);
    logic [17:0] obs;
    bus.mem_ready = mr;
    #1;
    obs = {bus.PCWrite, bus.IRWrite, bus.memRead, bus.memWrite, bus.regWrite,
           bus.memtoReg, bus.ALUOp, bus.ALUSrc, bus.PCSel, bus.IorD,
           bus.instr_done, bus.illegal, bus.state};
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [17:0] zero_v, f_rdy, f_stall, dec;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    zero_v  = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,3'd0);
    f_rdy   = v(1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,3'd0);
    f_stall = v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,3'd0);
    dec     = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,3'd1);

    rst = 1'b1;
    bus.opcode = 7'b0110011;
    bus.funct3 = 3'b000;
    bus.BrEq = 1'b0;
    bus.BrLT = 1'b0;
    bus.mem_ready = 1'b1;
    step("reset0", 1'b1, zero_v);
    step("reset1", 1'b1, zero_v);
    rst = 1'b0;

    // add with memory always ready
    step("add_fetch", 1'b1, f_rdy);
    step("add_decode", 1'b1, dec);
    step("add_exec", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b0,2'b00,1'b0,1'b0,1'b0,3'd2));
    step("add_wb", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b0,1'b1,1'b0,3'd4));

    // lw with one FETCH stall and two MEM stalls
    bus.opcode = 7'b0000011; bus.funct3 = 3'b010;
    step("lw_fetch_stall", 1'b0, f_stall);
    step("lw_fetch", 1'b1, f_rdy);
    step("lw_decode", 1'b0, dec);
    step("lw_exec", 1'b0, v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,3'd2));
    step("lw_mem_stall0", 1'b0, v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b1,1'b0,1'b0,3'd3));
    step("lw_mem_stall1", 1'b0, v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b1,1'b0,1'b0,3'd3));
    step("lw_mem_done", 1'b1, v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b1,1'b0,1'b0,3'd3));
    step("lw_wb", 1'b0, v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,2'b00,1'b0,1'b1,1'b0,3'd4));

    // beq taken then not taken
    bus.opcode = 7'b1100011; bus.funct3 = 3'b000; bus.BrEq = 1'b1;
    step("beq_t_fetch", 1'b1, f_rdy);
    step("beq_t_decode", 1'b1, dec);
    step("beq_t_exec", 1'b1, v(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b1,1'b0,3'd2));
    bus.BrEq = 1'b0;
    step("beq_n_fetch", 1'b1, f_rdy);
    step("beq_n_decode", 1'b1, dec);
    step("beq_n_exec", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b1,1'b0,3'd2));

    // bge taken (BrLT=0), bne not taken (BrEq=1)
    bus.funct3 = 3'b101; bus.BrLT = 1'b0;
    step("bge_fetch", 1'b1, f_rdy);
    step("bge_decode", 1'b1, dec);
    step("bge_exec", 1'b1, v(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b1,1'b0,3'd2));
    bus.funct3 = 3'b001; bus.BrEq = 1'b1;
    step("bne_fetch", 1'b1, f_rdy);
    step("bne_decode", 1'b1, dec);
    step("bne_exec", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b1,1'b0,3'd2));

    // jalr
    bus.opcode = 7'b1100111; bus.funct3 = 3'b000; bus.BrEq = 1'b0;
    step("jalr_fetch", 1'b1, f_rdy);
    step("jalr_decode", 1'b1, dec);
    step("jalr_exec", 1'b1, v(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,3'd2));
    step("jalr_wb", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,2'b00,1'b0,1'b1,1'b0,3'd4));

    // jal
    bus.opcode = 7'b1101111;
    step("jal_fetch", 1'b1, f_rdy);
    step("jal_decode", 1'b1, dec);
    step("jal_exec", 1'b1, v(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0,3'd2));
    step("jal_wb", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,2'b00,1'b0,1'b1,1'b0,3'd4));

    // I-type, mem_ready low outside FETCH/MEM must be ignored
    bus.opcode = 7'b0010011;
    step("addi_fetch", 1'b1, f_rdy);
    step("addi_decode", 1'b0, dec);
    step("addi_exec", 1'b0, v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,1'b1,2'b00,1'b0,1'b0,1'b0,3'd2));
    step("addi_wb", 1'b0, v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b0,1'b1,1'b0,3'd4));

    // illegal opcode
    bus.opcode = 7'b0000000;
    step("ill_fetch", 1'b1, f_rdy);
    step("ill_decode", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b1,1'b1,3'd1));

    // sw completing normally
    bus.opcode = 7'b0100011; bus.funct3 = 3'b010;
    step("sw_fetch", 1'b1, f_rdy);
    step("sw_decode", 1'b1, dec);
    step("sw_exec", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,3'd2));
    step("sw_mem", 1'b1, v(1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b1,2'b00,1'b1,1'b1,1'b0,3'd3));

    // sw stalled in MEM, then reset mid-instruction
    step("sw2_fetch", 1'b1, f_rdy);
    step("sw2_decode", 1'b1, dec);
    step("sw2_exec", 1'b1, v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,3'd2));
    step("sw2_mem_stall", 1'b0, v(1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b1,2'b00,1'b1,1'b0,1'b0,3'd3));
    rst = 1'b1;
    step("sw2_reset", 1'b0, zero_v);
    rst = 1'b0;
    step("post_reset_fetch", 1'b0, f_stall);
    step("post_reset_fetch_rdy", 1'b1, f_rdy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
